// File: rtl/mul_pkg.sv
// Shared state type, Booth digit select codes and default width for seq_booth_mul.
package mul_pkg;

   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Booth digit selects, packed as {neg, one, two}
   localparam logic [2:0] ZERO = 3'b000;
   localparam logic [2:0] POS1 = 3'b010;
   localparam logic [2:0] POS2 = 3'b001;
   localparam logic [2:0] NEG1 = 3'b110;
   localparam logic [2:0] NEG2 = 3'b101;

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window -> {neg, one, two} select.
module booth_r4_enc
   import mul_pkg::*;
(
   input  logic [2:0] win,
   output logic       neg,
   output logic       one,
   output logic       two
);

   logic [2:0] sel_s;

   // Window to digit select
   always_comb begin
      sel_s = ZERO;
      case (win)
         3'b000, 3'b111: sel_s = ZERO;
         3'b001, 3'b010: sel_s = POS1;
         3'b011:         sel_s = POS2;
         3'b100:         sel_s = NEG2;
         3'b101, 3'b110: sel_s = NEG1;
         default:        sel_s = ZERO;
      endcase
   end

   assign {neg, one, two} = sel_s;

endmodule

// File: rtl/seq_booth_mul.sv
// Iterative radix-4 Booth multiplier, one digit per clock, signed/unsigned, HI/LO product.
// Optional variable-latency early exit: define SEQ_BOOTH_MUL_EARLY_EXIT_EN.
module seq_booth_mul
   import mul_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int NDIG  = WIDTH / 2 + 1;
   localparam int ACC_W = 2 * WIDTH + 4;
   localparam int BW    = WIDTH + 3;
   localparam int CW    = $clog2(NDIG);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_t           state_r;
   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] mcand_r;
   logic [BW-1:0]    b_r;
   logic [CW-1:0]    cnt_r;

   logic [ACC_W-1:0] a_ext_s;
   logic [BW-1:0]    b_ext_s;
   logic [ACC_W-1:0] mag_s;
   logic [ACC_W-1:0] term_s;
   logic [ACC_W-1:0] acc_nxt_s;
   logic [BW-1:0]    b_nxt_s;
   logic             neg_s;
   logic             one_s;
   logic             two_s;
   logic             finish_s;

   // b_r[2:0] always holds the current window; the register shifts right two bits per digit
   booth_r4_enc u_enc (
      .win (b_r[2:0]),
      .neg (neg_s),
      .one (one_s),
      .two (two_s)
   );

   // Operand extension, partial-product selection and completion detect
   always_comb begin
      a_ext_s = {{(ACC_W - WIDTH){is_signed & A[WIDTH-1]}}, A};
      b_ext_s = {{2{is_signed & B[WIDTH-1]}}, B, 1'b0};
      if (two_s) begin
         mag_s = {mcand_r[ACC_W-2:0], 1'b0};
      end else if (one_s) begin
         mag_s = mcand_r;
      end else begin
         mag_s = '0;
      end
      term_s    = neg_s ? -mag_s : mag_s;
      acc_nxt_s = acc_r + term_s;
      b_nxt_s   = {{2{b_r[BW-1]}}, b_r[BW-1:2]};
`ifdef SEQ_BOOTH_MUL_EARLY_EXIT_EN
      // Remaining bits all equal to the sign means every later digit is zero
      finish_s  = (cnt_r == LAST) || (b_nxt_s == {BW{b_r[BW-1]}});
`else
      finish_s  = (cnt_r == LAST);
`endif
   end

   // Control FSM with datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (clr) begin
         state_r <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         HI      <= '0;
         LO      <= '0;
         acc_r   <= '0;
         mcand_r <= '0;
         b_r     <= '0;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand_r <= a_ext_s;
                  b_r     <= b_ext_s;
                  acc_r   <= '0;
                  cnt_r   <= '0;
                  busy    <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               acc_r   <= acc_nxt_s;
               mcand_r <= {mcand_r[ACC_W-3:0], 2'b00};
               b_r     <= b_nxt_s;
               cnt_r   <= cnt_r + CW'(1);
               if (finish_s) begin
                  HI      <= acc_nxt_s[2*WIDTH-1:WIDTH];
                  LO      <= acc_nxt_s[WIDTH-1:0];
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  state_r <= RUN;
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
